// File: rtl/rgb_pkg.sv
// rgb_pkg: shared definitions for the RGB expansion pipeline.
//   mode_e     - output mode encodings (RGB, grayscale, colour bars, reserved)
//   NUM_BARS   - number of vertical colour bars across the active line
//   bar_width  - pixels per colour bar for a given active line length
package rgb_pkg;

    typedef enum logic [1:0] {
        MODE_RGB  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_BARS = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int NUM_BARS = 8;

    // Bar width is the active line split evenly into NUM_BARS bars.
    function automatic int bar_width(input int h_active);
        return h_active / NUM_BARS;
    endfunction

endpackage

// File: rtl/chan_expand.sv
// chan_expand: combinational MSB-aligned bit replication of one colour channel.
// The IN_BITS input pattern is repeated from the MSB downwards and truncated
// to OUT_BITS, so full scale maps to full scale and zero maps to zero.
//   din  in  IN_BITS   narrow channel value
//   dout out OUT_BITS  expanded channel value
module chan_expand #(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 8
) (
    input  logic [IN_BITS-1:0]  din,
    output logic [OUT_BITS-1:0] dout
);

    // Output bit i (counted from the MSB) takes input bit (i mod IN_BITS) from the MSB.
    always_comb begin
        dout = {OUT_BITS{1'b0}};
        for (int i = 0; i < OUT_BITS; i++) begin
            dout[OUT_BITS-1-i] = din[IN_BITS-1-(i % IN_BITS)];
        end
    end

endmodule

// File: rtl/rgb_expand_pipe.sv
// rgb_expand_pipe: two-stage pixel pipeline expanding IN_BITS-per-channel RGB
// to OUT_BITS-per-channel, with grayscale and colour-bar test modes.
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 RGB, 1 gray from green, 2 colour bars, 3 reserved (black)
//   din        in   packed {R,G,B}, IN_BITS each, R in the MSBs
//   din_valid  in   din/nblank/syncs qualify this cycle
//   nblank     in   1 = display area
//   hsync_in   in   horizontal sync
//   vsync_in   in   vertical sync; its rising edge latches mode
//   r, g, b    out  expanded channels, 2 cycles after din
//   dout_valid, nblank_out, hsync_out, vsync_out  out  inputs delayed 2 cycles
module rgb_expand_pipe
    import rgb_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 8,
    parameter int H_ACTIVE = 640
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [3*IN_BITS-1:0]  din,
    input  logic                  din_valid,
    input  logic                  nblank,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output logic [OUT_BITS-1:0]   r,
    output logic [OUT_BITS-1:0]   g,
    output logic [OUT_BITS-1:0]   b,
    output logic                  dout_valid,
    output logic                  nblank_out,
    output logic                  hsync_out,
    output logic                  vsync_out
);

    localparam int                XW    = $clog2(H_ACTIVE);
    localparam int                BAR_W = bar_width(H_ACTIVE);
    localparam logic [XW-1:0]     X_MAX = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0]     X_ONE = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0]     BAR_W_X = XW'(BAR_W);
    localparam logic [OUT_BITS-1:0] ONES = {OUT_BITS{1'b1}};
    localparam logic [OUT_BITS-1:0] ZERO = {OUT_BITS{1'b0}};

    logic [IN_BITS-1:0]  r_in_s;
    logic [IN_BITS-1:0]  g_in_s;
    logic [IN_BITS-1:0]  b_in_s;
    logic [OUT_BITS-1:0] r_exp_s;
    logic [OUT_BITS-1:0] g_exp_s;
    logic [OUT_BITS-1:0] b_exp_s;
    logic [OUT_BITS-1:0] sel_r_s;
    logic [OUT_BITS-1:0] sel_g_s;
    logic [OUT_BITS-1:0] sel_b_s;
    logic [2:0]          bar_idx_s;

    logic [XW-1:0]       x_cnt_r;
    logic                vs_prev_r;
    mode_e               mode_act_r;

    logic [OUT_BITS-1:0] s1_r_r;
    logic [OUT_BITS-1:0] s1_g_r;
    logic [OUT_BITS-1:0] s1_b_r;
    logic                s1_valid_r;
    logic                s1_nblank_r;
    logic                s1_hsync_r;
    logic                s1_vsync_r;

    assign r_in_s = din[3*IN_BITS-1 -: IN_BITS];
    assign g_in_s = din[2*IN_BITS-1 -: IN_BITS];
    assign b_in_s = din[IN_BITS-1   -: IN_BITS];

    chan_expand #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_exp_r (.din(r_in_s), .dout(r_exp_s));
    chan_expand #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_exp_g (.din(g_in_s), .dout(g_exp_s));
    chan_expand #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_exp_b (.din(b_in_s), .dout(b_exp_s));

    // Bar index of the pixel presented this cycle; x_cnt never exceeds H_ACTIVE-1 so this stays 0..7.
    assign bar_idx_s = 3'(x_cnt_r / BAR_W_X);

    // Horizontal position: count active pixels, clear on a valid blank pixel, saturate at line end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_r <= {XW{1'b0}};
        end else if (din_valid) begin
            if (!nblank) begin
                x_cnt_r <= {XW{1'b0}};
            end else if (x_cnt_r != X_MAX) begin
                x_cnt_r <= x_cnt_r + X_ONE;
            end else begin
                x_cnt_r <= x_cnt_r;
            end
        end else begin
            x_cnt_r <= x_cnt_r;
        end
    end

    // Frame-synchronous mode: latch the mode input only on a vsync rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_r  <= 1'b0;
            mode_act_r <= MODE_RGB;
        end else begin
            vs_prev_r <= vsync_in;
            if (!vs_prev_r && vsync_in) begin
                mode_act_r <= mode_e'(mode);
            end else begin
                mode_act_r <= mode_act_r;
            end
        end
    end

    // Per-mode channel selection for the pixel entering stage 1.
    always_comb begin
        sel_r_s = ZERO;
        sel_g_s = ZERO;
        sel_b_s = ZERO;
        case (mode_act_r)
            MODE_RGB: begin
                sel_r_s = r_exp_s;
                sel_g_s = g_exp_s;
                sel_b_s = b_exp_s;
            end
            MODE_GRAY: begin
                sel_r_s = g_exp_s;
                sel_g_s = g_exp_s;
                sel_b_s = g_exp_s;
            end
            MODE_BARS: begin
                sel_r_s = bar_idx_s[2] ? ONES : ZERO;
                sel_g_s = bar_idx_s[1] ? ONES : ZERO;
                sel_b_s = bar_idx_s[0] ? ONES : ZERO;
            end
            MODE_RSVD: begin
                sel_r_s = ZERO;
                sel_g_s = ZERO;
                sel_b_s = ZERO;
            end
            default: begin
                sel_r_s = ZERO;
                sel_g_s = ZERO;
                sel_b_s = ZERO;
            end
        endcase
    end

    // Stage 1: register the selected colour and the control/sync bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r_r      <= ZERO;
            s1_g_r      <= ZERO;
            s1_b_r      <= ZERO;
            s1_valid_r  <= 1'b0;
            s1_nblank_r <= 1'b0;
            s1_hsync_r  <= 1'b0;
            s1_vsync_r  <= 1'b0;
        end else begin
            s1_r_r      <= sel_r_s;
            s1_g_r      <= sel_g_s;
            s1_b_r      <= sel_b_s;
            s1_valid_r  <= din_valid;
            s1_nblank_r <= nblank;
            s1_hsync_r  <= hsync_in;
            s1_vsync_r  <= vsync_in;
        end
    end

    // Stage 2: blank colour outside the display area and drive the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r          <= ZERO;
            g          <= ZERO;
            b          <= ZERO;
            dout_valid <= 1'b0;
            nblank_out <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
        end else begin
            r          <= s1_nblank_r ? s1_r_r : ZERO;
            g          <= s1_nblank_r ? s1_g_r : ZERO;
            b          <= s1_nblank_r ? s1_b_r : ZERO;
            dout_valid <= s1_valid_r;
            nblank_out <= s1_nblank_r;
            hsync_out  <= s1_hsync_r;
            vsync_out  <= s1_vsync_r;
        end
    end

endmodule

// File: tb/tb_rgb_expand_pipe.sv
// Directed testbench for rgb_expand_pipe: a 4->8 instance (main) and a
// 5->8 instance sharing the control inputs but with its own pixel input.
module tb_rgb_expand_pipe;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [11:0] din;
    logic [14:0] din5;
    logic        din_valid;
    logic        nblank;
    logic        hsync_in;
    logic        vsync_in;

    logic [7:0]  r, g, b;
    logic        dout_valid, nblank_out, hsync_out, vsync_out;
    logic [7:0]  r5, g5, b5;
    logic        dv5, nb5, hs5, vs5;

    int n_checks;
    int n_pass;

    rgb_expand_pipe #(.IN_BITS(4), .OUT_BITS(8), .H_ACTIVE(640)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .din_valid(din_valid),
        .nblank(nblank), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r(r), .g(g), .b(b), .dout_valid(dout_valid), .nblank_out(nblank_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    rgb_expand_pipe #(.IN_BITS(5), .OUT_BITS(8), .H_ACTIVE(640)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .din(din5), .din_valid(din_valid),
        .nblank(nblank), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r(r5), .g(g5), .b(b5), .dout_valid(dv5), .nblank_out(nb5),
        .hsync_out(hs5), .vsync_out(vs5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic nb, input logic hs, input logic vs,
                         input logic [11:0] d, input logic [14:0] d5);
        din_valid = v;
        nblank    = nb;
        hsync_in  = hs;
        vsync_in  = vs;
        din       = d;
        din5      = d5;
    endtask

    // One-cycle vsync pulse so the active mode loads m.
    task automatic new_frame(input logic [1:0] m);
        mode = m;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 15'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode  = 2'd0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 15'h7FFF);
        tick();
        tick();
        tick();
        n_checks++;
        if ({r, g, b, dout_valid, nblank_out, hsync_out, vsync_out} !== 28'h0)
            $display("FAIL reset_main: got %h %h %h %b%b%b%b, want all zero",
                     r, g, b, dout_valid, nblank_out, hsync_out, vsync_out);
        else n_pass++;
        n_checks++;
        if ({r5, g5, b5, dv5, nb5, hs5, vs5} !== 28'h0)
            $display("FAIL reset_5bit: got %h %h %h %b%b%b%b, want all zero",
                     r5, g5, b5, dv5, nb5, hs5, vs5);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_rgb();
        new_frame(2'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'hA5F, 15'b10110_00001_11111);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h123, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b, dout_valid, nblank_out} !== {24'hAA55FF, 1'b1, 1'b1})
            $display("FAIL rgb_a5f: got %h%h%h v%b nb%b, want AA55FF v1 nb1",
                     r, g, b, dout_valid, nblank_out);
        else n_pass++;
        n_checks++;
        if ({r5, g5, b5} !== 24'hB508FF)
            $display("FAIL rgb_5bit: got %h%h%h, want B508FF", r5, g5, b5);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b, dout_valid} !== {24'h112233, 1'b1})
            $display("FAIL rgb_123: got %h%h%h v%b, want 112233 v1", r, g, b, dout_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({r, g, b, dout_valid, nblank_out} !== {24'h000000, 1'b0, 1'b0})
            $display("FAIL rgb_idle: got %h%h%h v%b nb%b, want 000000 v0 nb0",
                     r, g, b, dout_valid, nblank_out);
        else n_pass++;
    endtask

    task automatic test_gray();
        new_frame(2'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h3C7, 15'h0000);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h3C7, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b, nblank_out} !== {24'hCCCCCC, 1'b1})
            $display("FAIL gray_3c7: got %h%h%h nb%b, want CCCCCC nb1", r, g, b, nblank_out);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b, dout_valid, nblank_out} !== {24'h000000, 1'b1, 1'b0})
            $display("FAIL gray_blank: got %h%h%h v%b nb%b, want 000000 v1 nb0",
                     r, g, b, dout_valid, nblank_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_bars();
        logic [23:0] exp_rgb;
        bit          do_chk;
        int          p;
        new_frame(2'd2);
        // A valid blank pixel starts the line at x = 0.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
        for (int i = 0; i <= 701; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 12'hA5F, 15'h0000);
            tick();
            p = i - 1;
            do_chk  = 1'b1;
            exp_rgb = 24'h000000;
            case (p)
                0, 79:        exp_rgb = 24'h000000;
                80, 159:      exp_rgb = 24'h0000FF;
                160:          exp_rgb = 24'h00FF00;
                320:          exp_rgb = 24'hFF0000;
                480:          exp_rgb = 24'hFFFF00;
                560, 639:     exp_rgb = 24'hFFFFFF;
                640, 700:     exp_rgb = 24'hFFFFFF;
                default:      do_chk = 1'b0;
            endcase
            if (do_chk) begin
                n_checks++;
                if ({r, g, b, dout_valid} !== {exp_rgb, 1'b1})
                    $display("FAIL bars_px%0d: got %h%h%h v%b, want %h v1",
                             p, r, g, b, dout_valid, exp_rgb);
                else n_pass++;
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
        tick();
        n_checks++;
        if ({r, g, b, nblank_out} !== {24'h000000, 1'b0})
            $display("FAIL bars_blank: got %h%h%h nb%b, want 000000 nb0", r, g, b, nblank_out);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
    endtask

    task automatic test_mode_change();
        new_frame(2'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'hA5F, 15'h0000);
        tick();
        mode = 2'd1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'hA5F, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b} !== 24'hAA55FF)
            $display("FAIL midframe_a: got %h%h%h, want AA55FF", r, g, b);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'hA5F, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b} !== 24'hAA55FF)
            $display("FAIL midframe_b: got %h%h%h, want AA55FF", r, g, b);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b} !== 24'hAA55FF)
            $display("FAIL midframe_c: got %h%h%h, want AA55FF", r, g, b);
        else n_pass++;
        new_frame(2'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 12'hA5F, 15'h0000);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b} !== 24'h555555)
            $display("FAIL newframe_gray: got %h%h%h, want 555555", r, g, b);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        // Active mode is gray here; stream one pixel to make outputs non-zero.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 12'hA5F, 15'h0000);
        tick();
        tick();
        n_checks++;
        if ({r, g, b, hsync_out} !== {24'h555555, 1'b1})
            $display("FAIL prereset: got %h%h%h hs%b, want 555555 hs1", r, g, b, hsync_out);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({r, g, b, dout_valid, nblank_out, hsync_out, vsync_out} !== 28'h0)
            $display("FAIL async_reset: got %h%h%h %b%b%b%b, want all zero",
                     r, g, b, dout_valid, nblank_out, hsync_out, vsync_out);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        // First pixel after release; active mode must be back to RGB.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 12'hA5F, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b, dout_valid, nblank_out, hsync_out, vsync_out} !== 28'h0)
            $display("FAIL post_rst_lat1: got %h%h%h %b%b%b%b, want all zero",
                     r, g, b, dout_valid, nblank_out, hsync_out, vsync_out);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b, dout_valid, nblank_out, hsync_out, vsync_out} !== {24'hAA55FF, 4'b1110})
            $display("FAIL post_rst_first: got %h%h%h %b%b%b%b, want AA55FF 1110",
                     r, g, b, dout_valid, nblank_out, hsync_out, vsync_out);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        tick();
        n_checks++;
        if ({r, g, b, dout_valid, nblank_out, hsync_out, vsync_out} !== {24'h000000, 4'b0001})
            $display("FAIL vsync_delay: got %h%h%h %b%b%b%b, want 000000 0001",
                     r, g, b, dout_valid, nblank_out, hsync_out, vsync_out);
        else n_pass++;
        tick();
        n_checks++;
        if ({dout_valid, nblank_out, hsync_out, vsync_out} !== 4'b0000)
            $display("FAIL sync_idle: got %b%b%b%b, want 0000",
                     dout_valid, nblank_out, hsync_out, vsync_out);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        mode     = 2'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 15'h0000);
        test_reset();
        test_rgb();
        test_gray();
        test_bars();
        test_mode_change();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
